// File: rtl/mem_fill_arbiter_if.sv
// Bundle of the cache-miss request, memory issue/return and fill-steering signals
// around mem_fill_arbiter. The arbiter connects through the master modport; the
// caches and memory side (or a bench) use the slave modport.
interface mem_fill_arbiter_if #(
   parameter int unsigned WORDS_PER_BLOCK = 8,
   parameter int unsigned ADDR_W          = 16,
   parameter int unsigned DATA_W          = 16
);
   localparam int unsigned WORD_W = $clog2(WORDS_PER_BLOCK);

   logic              icache_req;
   logic [ADDR_W-1:0] icache_addr;
   logic              dcache_req;
   logic [ADDR_W-1:0] dcache_addr;
   logic              mem_en;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_data_valid;
   logic [DATA_W-1:0] mem_data;
   logic [DATA_W-1:0] fill_data;
   logic [WORD_W-1:0] fill_word;
   logic              icache_fill_we;
   logic              dcache_fill_we;
   logic              icache_done;
   logic              dcache_done;
   logic              busy;

   modport master (
      input  icache_req, icache_addr, dcache_req, dcache_addr, mem_data_valid, mem_data,
      output mem_en, mem_addr, fill_data, fill_word, icache_fill_we, dcache_fill_we,
             icache_done, dcache_done, busy
   );

   modport slave (
      output icache_req, icache_addr, dcache_req, dcache_addr, mem_data_valid, mem_data,
      input  mem_en, mem_addr, fill_data, fill_word, icache_fill_we, dcache_fill_we,
             icache_done, dcache_done, busy
   );
endinterface

// File: rtl/mem_fill_arbiter.sv
// Shared memory-port fill arbiter for the I-cache and D-cache. Grants one miss at a
// time, issues one word read per cycle for the whole block, steers returning beats to
// the owner with a word index and pulses the owner's done when the block is complete.
// Optional: define ROUND_ROBIN_EN to alternate grants between simultaneous requesters
// (otherwise D-cache has fixed priority over I-cache).
module mem_fill_arbiter #(
   parameter int unsigned WORDS_PER_BLOCK = 8,
   parameter int unsigned ADDR_W          = 16,
   parameter int unsigned DATA_W          = 16
) (
   input logic               clk,
   input logic               rst,
   mem_fill_arbiter_if.master bus
);
   localparam int unsigned WORD_W = $clog2(WORDS_PER_BLOCK);
   localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_BLOCK - 1);
   // Byte offset bits within a block (word index plus the byte-in-word bit)
   localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(2 * WORDS_PER_BLOCK - 1);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StIssue = 2'd1;
   localparam logic [1:0] StWait  = 2'd2;
   localparam logic [1:0] StDone  = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [1:0]        owner_q, owner_d;  // one-hot {dcache, icache}, 0 = none
   logic [ADDR_W-1:0] base_q, base_d;
   logic [WORD_W-1:0] issue_cnt_q, issue_cnt_d;
   logic [WORD_W-1:0] recv_cnt_q, recv_cnt_d;
   logic              grant_d, grant_i, beat;

`ifdef ROUND_ROBIN_EN
   logic              last_d_q, last_d_d;  // 1: previous fill owned by D-cache

   // Alternate on contention: D wins only if I owned the previous fill
   always_comb begin
      grant_d = bus.dcache_req && (!bus.icache_req || !last_d_q);
      grant_i = bus.icache_req && !grant_d;
   end
`else
   // Fixed priority: D-cache over I-cache
   always_comb begin
      grant_d = bus.dcache_req;
      grant_i = bus.icache_req && !bus.dcache_req;
   end
`endif

   // Beats are only accepted while a fill is active; stray returns are dropped
   assign beat = bus.mem_data_valid && ((state_q == StIssue) || (state_q == StWait));

   // Next-state: grant, issue sequencing and beat counting
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      base_d      = base_q;
      issue_cnt_d = issue_cnt_q;
      recv_cnt_d  = recv_cnt_q;
`ifdef ROUND_ROBIN_EN
      last_d_d    = last_d_q;
`endif
      case (state_q)
         StIdle: begin
            if (grant_d || grant_i) begin
               owner_d     = {grant_d, grant_i};
               base_d      = (grant_d ? bus.dcache_addr : bus.icache_addr) & ~OFF_MASK;
               issue_cnt_d = '0;
               recv_cnt_d  = '0;
               state_d     = StIssue;
`ifdef ROUND_ROBIN_EN
               last_d_d    = grant_d;
`endif
            end
         end
         StIssue: begin
            issue_cnt_d = issue_cnt_q + 1'b1;
            if (issue_cnt_q == LAST_WORD) state_d = StWait;
         end
         StWait: ;
         StDone: begin
            state_d = StIdle;
            owner_d = '0;
         end
         default: state_d = StIdle;
      endcase
      // The final beat completes the block from either ISSUE or WAIT
      if (beat) begin
         recv_cnt_d = recv_cnt_q + 1'b1;
         if (recv_cnt_q == LAST_WORD) state_d = StDone;
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         owner_q     <= '0;
         base_q      <= '0;
         issue_cnt_q <= '0;
         recv_cnt_q  <= '0;
`ifdef ROUND_ROBIN_EN
         last_d_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         base_q      <= base_d;
         issue_cnt_q <= issue_cnt_d;
         recv_cnt_q  <= recv_cnt_d;
`ifdef ROUND_ROBIN_EN
         last_d_q    <= last_d_d;
`endif
      end
   end

   // Outputs: memory issue, fill steering and completion pulses
   always_comb begin
      bus.mem_en         = (state_q == StIssue);
      bus.mem_addr       = bus.mem_en ? (base_q + (ADDR_W'(issue_cnt_q) << 1)) : '0;
      bus.fill_data      = bus.mem_data;
      bus.fill_word      = beat ? recv_cnt_q : '0;
      bus.icache_fill_we = beat && owner_q[0];
      bus.dcache_fill_we = beat && owner_q[1];
      bus.icache_done    = (state_q == StDone) && owner_q[0];
      bus.dcache_done    = (state_q == StDone) && owner_q[1];
      bus.busy           = (state_q != StIdle);
   end
endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Scoreboard bench for mem_fill_arbiter: a fixed-latency memory model answers issued
// reads, the stimulus pushes the expected issue addresses, beats and done pulses of
// each fill in the order the grant rules dictate, and a negedge monitor checks them.
module tb_mem_fill_arbiter;
   localparam int unsigned WPB = 8;
   localparam int unsigned AW  = 16;
   localparam int unsigned DW  = 16;

   typedef struct packed {
      logic        own_d;
      logic [2:0]  word;
      logic [15:0] data;
   } beat_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_fill_arbiter_if #(.WORDS_PER_BLOCK(WPB), .ADDR_W(AW), .DATA_W(DW)) bus ();
   mem_fill_arbiter #(.WORDS_PER_BLOCK(WPB), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int lat = 4;
   bit stray = 1'b0;
   bit model_last_d = 1'b0;
   logic [15:0] ret_q [int];
   logic [15:0] exp_addr [$];
   beat_t       exp_beat [$];
   bit          exp_done [$];
   int i_done_cnt = 0;
   int d_done_cnt = 0;
   int last_beat_cyc = -10;
   int last_en_cyc = -10;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] mdata(input logic [15:0] a);
      return (a * 16'd7) ^ 16'h5A5A;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Memory model: fixed latency, answers each issued read lat cycles later
   initial begin
      bus.mem_data_valid = 1'b0;
      bus.mem_data = '0;
      forever begin
         @(negedge clk);
         if (bus.mem_en === 1'b1) ret_q[cyc + lat] = bus.mem_addr;
         @(posedge clk);
         #1;
         if (ret_q.exists(cyc)) begin
            bus.mem_data_valid = 1'b1;
            bus.mem_data = mdata(ret_q[cyc]);
            ret_q.delete(cyc);
         end else begin
            bus.mem_data_valid = stray;
            bus.mem_data = 16'($urandom);
         end
      end
   end

   // Monitor: compare every issue, beat and done against the scoreboard
   initial begin
      logic [15:0] a;
      beat_t b;
      bit od;
      forever begin
         @(negedge clk);
         if (bus.mem_en === 1'b1) begin
            checks++;
            if (exp_addr.size() == 0) begin
               errors++;
               $display("FAIL issue: got unexpected addr %0h expected no issue", bus.mem_addr);
            end else begin
               a = exp_addr.pop_front();
               if (bus.mem_addr !== a || ((a & 16'hF) != 0 && last_en_cyc != cyc - 1)) begin
                  errors++;
                  $display("FAIL issue: got addr %0h (prev en cyc %0d, now %0d) expected %0h",
                           bus.mem_addr, last_en_cyc, cyc, a);
               end
            end
            last_en_cyc = cyc;
         end
         if (bus.icache_fill_we === 1'b1 || bus.dcache_fill_we === 1'b1) begin
            checks++;
            if (exp_beat.size() == 0 || (bus.icache_fill_we && bus.dcache_fill_we)) begin
               errors++;
               $display("FAIL beat: got we i=%b d=%b word %0d expected no beat",
                        bus.icache_fill_we, bus.dcache_fill_we, bus.fill_word);
            end else begin
               b = exp_beat.pop_front();
               if (bus.dcache_fill_we !== b.own_d || bus.fill_word !== b.word ||
                   bus.fill_data !== b.data) begin
                  errors++;
                  $display("FAIL beat: got own_d %b word %0d data %0h expected %b %0d %0h",
                           bus.dcache_fill_we, bus.fill_word, bus.fill_data,
                           b.own_d, b.word, b.data);
               end
            end
            last_beat_cyc = cyc;
         end
         if (bus.icache_done === 1'b1 || bus.dcache_done === 1'b1) begin
            checks++;
            if (exp_done.size() == 0 || (bus.icache_done && bus.dcache_done)) begin
               errors++;
               $display("FAIL done: got i=%b d=%b expected no done",
                        bus.icache_done, bus.dcache_done);
            end else begin
               od = exp_done.pop_front();
               if (bus.dcache_done !== od || last_beat_cyc != cyc - 1 || bus.busy !== 1'b1) begin
                  errors++;
                  $display("FAIL done: got d=%b beat_gap %0d busy %b expected d=%b gap 1 busy 1",
                           bus.dcache_done, cyc - last_beat_cyc, bus.busy, od);
               end
            end
            if (bus.icache_done === 1'b1) i_done_cnt++;
            if (bus.dcache_done === 1'b1) d_done_cnt++;
         end
      end
   end

   // Expected trace of one whole-block fill
   task automatic push_fill(input bit own_d, input logic [15:0] addr);
      logic [15:0] base;
      base = addr & ~16'(2 * WPB - 1);
      for (int k = 0; k < WPB; k++) begin
         exp_addr.push_back(base + 16'(2 * k));
         exp_beat.push_back('{own_d, 3'(k), mdata(base + 16'(2 * k))});
      end
      exp_done.push_back(own_d);
   endtask

   // Grant order: requesters stay up for n fills each, re-arbitrated every idle cycle
   task automatic plan(input int n_i, input int n_d, input logic [15:0] ai,
                       input logic [15:0] ad);
      bit pick_d;
      while (n_i > 0 || n_d > 0) begin
         if (n_i > 0 && n_d > 0) begin
`ifdef ROUND_ROBIN_EN
            pick_d = !model_last_d;
`else
            pick_d = 1'b1;
`endif
         end else begin
            pick_d = (n_d > 0);
         end
         push_fill(pick_d, pick_d ? ad : ai);
         model_last_d = pick_d;
         if (pick_d) n_d--;
         else n_i--;
      end
   endtask

   task automatic run(input int n_i, input int n_d, input logic [15:0] ai,
                      input logic [15:0] ad, input int l);
      int ci0, cd0, last_tot;
      bit ok;
      lat = l;
      plan(n_i, n_d, ai, ad);
      ci0 = i_done_cnt;
      cd0 = d_done_cnt;
      last_tot = ci0 + cd0;
      bus.icache_addr = ai;
      bus.dcache_addr = ad;
      bus.icache_req = (n_i > 0);
      bus.dcache_req = (n_d > 0);
      ok = 1'b0;
      for (int t = 0; t < 600; t++) begin
         tick();
         if (i_done_cnt + d_done_cnt != last_tot) begin
            last_tot = i_done_cnt + d_done_cnt;
            chk("busy_after_done", 32'(bus.busy), 32'd0);
         end
         if (i_done_cnt - ci0 >= n_i) bus.icache_req = 1'b0;
         if (d_done_cnt - cd0 >= n_d) bus.dcache_req = 1'b0;
         if (!bus.icache_req && !bus.dcache_req && exp_addr.size() == 0 &&
             exp_beat.size() == 0 && exp_done.size() == 0 && bus.busy === 1'b0 &&
             ret_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL fill_timeout: got pending addr %0d beat %0d done %0d expected 0 0 0",
                  exp_addr.size(), exp_beat.size(), exp_done.size());
         exp_addr.delete();
         exp_beat.delete();
         exp_done.delete();
         bus.icache_req = 1'b0;
         bus.dcache_req = 1'b0;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got time limit expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      int ni, nd;
      rst = 1'b1;
      bus.icache_req = 1'b0;
      bus.dcache_req = 1'b0;
      bus.icache_addr = '0;
      bus.dcache_addr = '0;
      repeat (3) tick();
      chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
      chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_we", 32'({bus.icache_fill_we, bus.dcache_fill_we}), 32'd0);
      chk("rst_done", 32'({bus.icache_done, bus.dcache_done}), 32'd0);
      chk("rst_fill_word", 32'(bus.fill_word), 32'd0);
      rst = 1'b0;
      tick();

      run(1, 0, 16'h1236, 16'h0000, 4);
      run(1, 1, 16'h2000, 16'h0040, 3);

      // Stray returns while idle must not write or wake the arbiter
      stray = 1'b1;
      repeat (4) begin
         tick();
         chk("idle_stray_we", 32'({bus.icache_fill_we, bus.dcache_fill_we}), 32'd0);
         chk("idle_stray_busy", 32'(bus.busy), 32'd0);
      end
      stray = 1'b0;
      tick();

      // Reset on the third issue cycle: abort, no done, late beats ignored
      lat = 4;
      exp_addr.push_back(16'h3450);
      exp_addr.push_back(16'h3452);
      exp_addr.push_back(16'h3454);
      bus.icache_addr = 16'h3456;
      bus.icache_req = 1'b1;
      seen = 1'b0;
      for (int t = 0; t < 20 && !seen; t++) begin
         tick();
         seen = (bus.mem_en === 1'b1);
      end
      chk("rst_test_issue_seen", 32'(seen), 32'd1);
      tick();
      tick();
      rst = 1'b1;
      bus.icache_req = 1'b0;
      tick();
      chk("midrst_busy", 32'(bus.busy), 32'd0);
      chk("midrst_mem_en", 32'(bus.mem_en), 32'd0);
      rst = 1'b0;
      model_last_d = 1'b0;
      repeat (10) begin
         tick();
         chk("midrst_late_we", 32'({bus.icache_fill_we, bus.dcache_fill_we}), 32'd0);
         chk("midrst_done", 32'({bus.icache_done, bus.dcache_done}), 32'd0);
      end
      chk("midrst_issues", 32'(exp_addr.size()), 32'd0);
      exp_addr.delete();

      run(1, 0, 16'h4A1C, 16'h0000, 1);
      run(2, 0, 16'h0100, 16'h0000, 2);
      run(0, 1, 16'h0000, 16'h7770, 3);
      run(1, 1, 16'h2000, 16'h0040, 2);

      for (int it = 0; it < 25; it++) begin
         ni = $urandom_range(0, 2);
         nd = $urandom_range(0, 2);
         if (ni == 0 && nd == 0) ni = 1;
         run(ni, nd, 16'($urandom), 16'($urandom), $urandom_range(1, 6));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
